// File: rtl/demux_striping_pkg.sv
// Shared definitions for the two-lane striper and its companion unstriping mux.
// Holds the default word width and the selector FSM encodings.
`default_nettype none

package demux_striping_pkg;

   localparam int DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEL1 = 2'd1,
      ST_SEL0 = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/demux_striping_lane_reg.sv
// One lane holding register: word plus valid.
// Clear wins over write; the word is held while neither is asserted.
`default_nettype none

module lane_reg
   import demux_striping_pkg::*;
#(
   parameter int DATA_WIDTH = demux_striping_pkg::DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic                  clr,
   input  logic [DATA_WIDTH-1:0] d,
   output logic [DATA_WIDTH-1:0] q,
   output logic                  v
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= '0;
         v <= 1'b0;
      end else if (clr) begin
         q <= '0;
         v <= 1'b0;
      end else if (wr_en) begin
         q <= d;
         v <= 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/demux_striping.sv
// Transmit-side lane striper: alternates a valid-qualified word stream across two lanes,
// starting every burst on lane0 and clearing both lanes on the first idle cycle.
`default_nettype none

module demux_striping
   import demux_striping_pkg::*;
#(
   parameter int DATA_WIDTH = demux_striping_pkg::DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  valid_in,
   output logic [DATA_WIDTH-1:0] lane_out0,
   output logic                  valid_out0,
   output logic [DATA_WIDTH-1:0] lane_out1,
   output logic                  valid_out1,
   output logic                  active
);

   state_t state;
   logic   wr_en0;
   logic   wr_en1;
   logic   clr;

   // Only SEL1 steers to lane1; IDLE and SEL0 both target lane0.
   always_comb begin
      wr_en0 = 1'b0;
      wr_en1 = 1'b0;
      clr    = 1'b0;
      if (!valid_in) begin
         clr = 1'b1;
      end else if (state == ST_SEL1) begin
         wr_en1 = 1'b1;
      end else begin
         wr_en0 = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= ST_IDLE;
         active <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               state  <= valid_in ? ST_SEL1 : ST_IDLE;
               active <= valid_in;
            end
            ST_SEL1: begin
               state  <= valid_in ? ST_SEL0 : ST_IDLE;
               active <= valid_in;
            end
            ST_SEL0: begin
               state  <= valid_in ? ST_SEL1 : ST_IDLE;
               active <= valid_in;
            end
            default: begin
               state  <= ST_IDLE;
               active <= 1'b0;
            end
         endcase
      end
   end

   lane_reg #(.DATA_WIDTH(DATA_WIDTH)) u_lane0 (
      .clk   (clk),
      .reset (reset),
      .wr_en (wr_en0),
      .clr   (clr),
      .d     (data_in),
      .q     (lane_out0),
      .v     (valid_out0)
   );

   lane_reg #(.DATA_WIDTH(DATA_WIDTH)) u_lane1 (
      .clk   (clk),
      .reset (reset),
      .wr_en (wr_en1),
      .clr   (clr),
      .d     (data_in),
      .q     (lane_out1),
      .v     (valid_out1)
   );

endmodule

`default_nettype wire

// File: tb/tb_demux_striping.sv
// Directed self-checking bench for demux_striping.
`default_nettype none

module tb_demux_striping;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] data_in;
   logic          valid_in;
   logic [DW-1:0] lane_out0;
   logic          valid_out0;
   logic [DW-1:0] lane_out1;
   logic          valid_out1;
   logic          active;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic          vin;
      logic [DW-1:0] din;
      logic [DW-1:0] e0;
      logic          ev0;
      logic [DW-1:0] e1;
      logic          ev1;
      logic          eact;
   } vec_t;

   demux_striping #(.DATA_WIDTH(DW)) dut (
      .clk        (clk),
      .reset      (reset),
      .data_in    (data_in),
      .valid_in   (valid_in),
      .lane_out0  (lane_out0),
      .valid_out0 (valid_out0),
      .lane_out1  (lane_out1),
      .valid_out1 (valid_out1),
      .active     (active)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vectors(input string name, input vec_t v[]);
      for (int i = 0; i < v.size(); i++) begin
         valid_in = v[i].vin;
         data_in  = v[i].din;
         tick();
         n_checks++;
         if ({lane_out0, valid_out0, lane_out1, valid_out1, active} !==
             {v[i].e0, v[i].ev0, v[i].e1, v[i].ev1, v[i].eact}) begin
            n_fail++;
            $display("FAIL %s step %0d: got l0=%h v0=%b l1=%h v1=%b act=%b, want l0=%h v0=%b l1=%h v1=%b act=%b",
                     name, i, lane_out0, valid_out0, lane_out1, valid_out1, active,
                     v[i].e0, v[i].ev0, v[i].e1, v[i].ev1, v[i].eact);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         valid_in = 1'($urandom_range(0, 1));
         data_in  = $urandom;
         tick();
         n_checks++;
         if ({lane_out0, valid_out0, lane_out1, valid_out1, active} !== {(2 * DW + 3){1'b0}}) begin
            n_fail++;
            $display("FAIL reset cycle %0d: got l0=%h v0=%b l1=%h v1=%b act=%b, want all 0",
                     i, lane_out0, valid_out0, lane_out1, valid_out1, active);
         end
      end
      valid_in = 1'b0;
      data_in  = '0;
      reset    = 1'b1;
      tick();
   endtask

   task automatic test_burst();
      vec_t v[] = '{
         '{1'b1, 32'hA0, 32'hA0, 1'b1, 32'h0,  1'b0, 1'b1},
         '{1'b1, 32'hA1, 32'hA0, 1'b1, 32'hA1, 1'b1, 1'b1},
         '{1'b1, 32'hA2, 32'hA2, 1'b1, 32'hA1, 1'b1, 1'b1},
         '{1'b1, 32'hA3, 32'hA2, 1'b1, 32'hA3, 1'b1, 1'b1},
         '{1'b0, 32'h0,  32'h0,  1'b0, 32'h0,  1'b0, 1'b0}
      };
      run_vectors("burst", v);
   endtask

   task automatic test_odd_burst();
      vec_t v[] = '{
         '{1'b1, 32'h11, 32'h11, 1'b1, 32'h0,  1'b0, 1'b1},
         '{1'b1, 32'h22, 32'h11, 1'b1, 32'h22, 1'b1, 1'b1},
         '{1'b1, 32'h33, 32'h33, 1'b1, 32'h22, 1'b1, 1'b1},
         '{1'b0, 32'h55, 32'h0,  1'b0, 32'h0,  1'b0, 1'b0},
         '{1'b1, 32'h44, 32'h44, 1'b1, 32'h0,  1'b0, 1'b1},
         '{1'b0, 32'h0,  32'h0,  1'b0, 32'h0,  1'b0, 1'b0}
      };
      run_vectors("odd_burst", v);
   endtask

   task automatic test_reset_mid_burst();
      vec_t pre[] = '{
         '{1'b1, 32'hB0, 32'hB0, 1'b1, 32'h0,  1'b0, 1'b1},
         '{1'b1, 32'hB1, 32'hB0, 1'b1, 32'hB1, 1'b1, 1'b1}
      };
      vec_t post[] = '{
         '{1'b1, 32'hB2, 32'hB2, 1'b1, 32'h0,  1'b0, 1'b1},
         '{1'b0, 32'h0,  32'h0,  1'b0, 32'h0,  1'b0, 1'b0}
      };
      run_vectors("mid_reset_pre", pre);
      // Assert and release entirely between clock edges.
      reset = 1'b0;
      #2;
      n_checks++;
      if ({lane_out0, valid_out0, lane_out1, valid_out1, active} !== {(2 * DW + 3){1'b0}}) begin
         n_fail++;
         $display("FAIL async_reset: got l0=%h v0=%b l1=%h v1=%b act=%b, want all 0",
                  lane_out0, valid_out0, lane_out1, valid_out1, active);
      end
      reset = 1'b1;
      run_vectors("mid_reset_post", post);
   endtask

   task automatic test_idle_toggle();
      for (int i = 0; i < 6; i++) begin
         valid_in = 1'b0;
         data_in  = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0;
         tick();
         n_checks++;
         if ({lane_out0, valid_out0, lane_out1, valid_out1, active} !== {(2 * DW + 3){1'b0}}) begin
            n_fail++;
            $display("FAIL idle_toggle cycle %0d: got l0=%h v0=%b l1=%h v1=%b act=%b, want all 0",
                     i, lane_out0, valid_out0, lane_out1, valid_out1, active);
         end
      end
   endtask

   // Reassemble the stream from the lanes: word k of a burst is read from lane k%2.
   task automatic test_loopback();
      logic [DW-1:0] sent[$];
      logic [DW-1:0] got[$];
      logic [DW-1:0] prev;
      logic [DW-1:0] w;
      int            idx;
      int            cyc;
      idx = 0;
      cyc = 0;
      prev = '0;
      while (sent.size() < 64 && cyc < 500) begin
         cyc++;
         if ($urandom_range(0, 3) == 0) begin
            valid_in = 1'b0;
            data_in  = $urandom;
            tick();
            idx = 0;
            n_checks++;
            if ({valid_out0, valid_out1, active} !== 3'b000) begin
               n_fail++;
               $display("FAIL loopback_gap cycle %0d: got v0=%b v1=%b act=%b, want 000",
                        cyc, valid_out0, valid_out1, active);
            end
         end else begin
            w        = $urandom;
            valid_in = 1'b1;
            data_in  = w;
            sent.push_back(w);
            tick();
            got.push_back((idx % 2 == 0) ? lane_out0 : lane_out1);
            n_checks++;
            if (idx % 2 == 0) begin
               if ({lane_out0, valid_out0, active} !== {w, 1'b1, 1'b1} ||
                   (idx > 0 && {lane_out1, valid_out1} !== {prev, 1'b1}) ||
                   (idx == 0 && valid_out1 !== 1'b0)) begin
                  n_fail++;
                  $display("FAIL loopback_lane0 word %0d: got l0=%h v0=%b l1=%h v1=%b act=%b, want l0=%h l1=%h",
                           sent.size() - 1, lane_out0, valid_out0, lane_out1, valid_out1, active, w, prev);
               end
            end else begin
               if ({lane_out1, valid_out1, lane_out0, valid_out0, active} !== {w, 1'b1, prev, 1'b1, 1'b1}) begin
                  n_fail++;
                  $display("FAIL loopback_lane1 word %0d: got l0=%h v0=%b l1=%h v1=%b act=%b, want l0=%h l1=%h",
                           sent.size() - 1, lane_out0, valid_out0, lane_out1, valid_out1, active, prev, w);
               end
            end
            prev = w;
            idx++;
         end
      end
      valid_in = 1'b0;
      tick();
      n_checks++;
      if (sent.size() != 64 || got.size() != 64 || got != sent) begin
         n_fail++;
         $display("FAIL loopback_stream: got %0d words reassembled, want 64 words in order (sent %0d)",
                  got.size(), sent.size());
      end
   endtask

   initial begin
      reset    = 1'b0;
      valid_in = 1'b0;
      data_in  = '0;
      test_reset();
      test_burst();
      test_odd_burst();
      test_reset_mid_burst();
      test_idle_toggle();
      test_loopback();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
